// File: rtl/wrb_stg_mc.sv
// wrb_stg_mc: multi-lane writeback FIFO with lane compaction, $0 filtering and same-group WAW coalescing
module wrb_stg_mc #(
  parameter int NUM_CH = 2,
  parameter int NUM_WP = 2,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          mem_wrb_vld,
  input  logic [NUM_CH-1:0]          mem_wrb_dst_vld,
  input  logic [NUM_CH*ADDR_W-1:0]   mem_wrb_dst_reg,
  input  logic [NUM_CH*DATA_W-1:0]   mem_wrb_data,
  output logic                       mem_wrb_rdy,
  output logic [NUM_WP-1:0]          wrb_dec_vld,
  output logic [NUM_WP*ADDR_W-1:0]   wrb_dec_addr,
  output logic [NUM_WP*DATA_W-1:0]   wrb_dec_data,
  output logic [$clog2(DEPTH):0]     wrb_occ
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, push_n, pop_n;
  logic              fifo_dv   [DEPTH];
  logic [ADDR_W-1:0] fifo_reg  [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     slot   [NUM_CH];
  logic [PW-1:0]     rd_idx [NUM_WP];
  logic [NUM_WP-1:0] cand, wr_en;
  assign mem_wrb_rdy = (CW'(DEPTH) - count) >= CW'(NUM_CH);
  assign wrb_occ     = count;
  // Valid lanes take consecutive slots; each lane's offset is the number of valid lanes below it.
  always_comb begin
    push_n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      slot[i] = wr_ptr + push_n[PW-1:0];
      push_n  = push_n + CW'(mem_wrb_vld[i]);
    end
  end
  // An older write in the pop group is dropped when a younger one in the same group hits the same register.
  always_comb begin
    pop_n = (count > CW'(NUM_WP)) ? CW'(NUM_WP) : count;
    for (int k = 0; k < NUM_WP; k++) begin
      rd_idx[k] = rd_ptr + PW'(k);
      cand[k]   = (CW'(k) < pop_n) && fifo_dv[rd_idx[k]] && (fifo_reg[rd_idx[k]] != '0);
    end
    for (int k = 0; k < NUM_WP; k++) begin
      wr_en[k] = cand[k];
      for (int j = k + 1; j < NUM_WP; j++)
        if (cand[j] && fifo_reg[rd_idx[j]] == fifo_reg[rd_idx[k]]) wr_en[k] = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      wrb_dec_vld  <= '0;
      wrb_dec_addr <= '0;
      wrb_dec_data <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_dv[i] <= 1'b0;
    end else begin
      if (mem_wrb_rdy)
        for (int i = 0; i < NUM_CH; i++)
          if (mem_wrb_vld[i]) begin
            fifo_dv[slot[i]]   <= mem_wrb_dst_vld[i];
            fifo_reg[slot[i]]  <= mem_wrb_dst_reg[i*ADDR_W +: ADDR_W];
            fifo_data[slot[i]] <= mem_wrb_data[i*DATA_W +: DATA_W];
          end
      wr_ptr <= wr_ptr + (mem_wrb_rdy ? push_n[PW-1:0] : '0);
      rd_ptr <= rd_ptr + pop_n[PW-1:0];
      count  <= count + (mem_wrb_rdy ? push_n : '0) - pop_n;
      for (int k = 0; k < NUM_WP; k++) begin
        wrb_dec_vld[k]                   <= wr_en[k];
        wrb_dec_addr[k*ADDR_W +: ADDR_W] <= wr_en[k] ? fifo_reg[rd_idx[k]] : '0;
        wrb_dec_data[k*DATA_W +: DATA_W] <= wr_en[k] ? fifo_data[rd_idx[k]] : '0;
      end
    end
  end
endmodule

// File: tb/tb_wrb_stg_mc.sv
// tb_wrb_stg_mc: queue-model bench for a 2-port instance and a 1-port instance that fills and wraps
module tb_wrb_stg_mc;
  localparam int NC = 2, D = 8, AW = 5, DW = 32;
  typedef struct {bit dv; bit [AW-1:0] r; bit [DW-1:0] d;} ent_t;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [NC-1:0] a_vld, a_dv, b_vld, b_dv;
  logic [NC*AW-1:0] a_reg, b_reg;
  logic [NC*DW-1:0] a_data, b_data;
  logic a_rdy, b_rdy;
  logic [1:0] a_ovld;
  logic [2*AW-1:0] a_oaddr;
  logic [2*DW-1:0] a_odata;
  logic [0:0] b_ovld;
  logic [AW-1:0] b_oaddr;
  logic [DW-1:0] b_odata;
  logic [3:0] a_occ, b_occ;
  wrb_stg_mc #(.NUM_CH(NC), .NUM_WP(2), .DEPTH(D), .ADDR_W(AW), .DATA_W(DW)) u_a (
    .clk(clk), .reset(reset), .mem_wrb_vld(a_vld), .mem_wrb_dst_vld(a_dv), .mem_wrb_dst_reg(a_reg),
    .mem_wrb_data(a_data), .mem_wrb_rdy(a_rdy), .wrb_dec_vld(a_ovld), .wrb_dec_addr(a_oaddr),
    .wrb_dec_data(a_odata), .wrb_occ(a_occ));
  wrb_stg_mc #(.NUM_CH(NC), .NUM_WP(1), .DEPTH(D), .ADDR_W(AW), .DATA_W(DW)) u_b (
    .clk(clk), .reset(reset), .mem_wrb_vld(b_vld), .mem_wrb_dst_vld(b_dv), .mem_wrb_dst_reg(b_reg),
    .mem_wrb_data(b_data), .mem_wrb_rdy(b_rdy), .wrb_dec_vld(b_ovld), .wrb_dec_addr(b_oaddr),
    .wrb_dec_data(b_odata), .wrb_occ(b_occ));
  int n_chk = 0, n_fail = 0, b_acc_cnt = 0, b_wr_cnt = 0;
  bit chk_en = 0;
  function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic logic [AW-1:0] rg(int s);
    return AW'(s % 31 + 1);
  endfunction
  // Reference: a program-order queue of entries; each edge pops the oldest group and appends accepted lanes.
  ent_t qa[$], qb[$], g[$];
  ent_t e;
  bit acc_a, acc_b, w;
  int n;
  bit [1:0] ea_vld;
  bit [AW-1:0] ea_addr [2];
  bit [DW-1:0] ea_data [2];
  bit eb_vld;
  bit [AW-1:0] eb_addr;
  bit [DW-1:0] eb_data;
  always @(posedge clk) begin
    ea_vld = '0; ea_addr = '{default: '0}; ea_data = '{default: '0};
    eb_vld = 1'b0; eb_addr = '0; eb_data = '0;
    if (reset) begin
      qa.delete();
      qb.delete();
    end else begin
      acc_a = (D - qa.size()) >= NC;
      acc_b = (D - qb.size()) >= NC;
      n = qa.size() < 2 ? qa.size() : 2;
      g = {};
      for (int k = 0; k < n; k++) g.push_back(qa.pop_front());
      for (int k = 0; k < n; k++) begin
        w = g[k].dv && g[k].r != 0;
        for (int j = k + 1; j < n; j++) if (g[j].dv && g[j].r == g[k].r) w = 0;
        if (w) begin ea_vld[k] = 1'b1; ea_addr[k] = g[k].r; ea_data[k] = g[k].d; end
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        if (e.dv && e.r != 0) begin eb_vld = 1'b1; eb_addr = e.r; eb_data = e.d; end
      end
      for (int i = 0; i < NC; i++) begin
        if (acc_a && a_vld[i]) qa.push_back(ent_t'{a_dv[i], a_reg[i*AW +: AW], a_data[i*DW +: DW]});
        if (acc_b && b_vld[i]) begin
          qb.push_back(ent_t'{b_dv[i], b_reg[i*AW +: AW], b_data[i*DW +: DW]});
          b_acc_cnt++;
        end
      end
    end
  end
  always @(negedge clk) if (chk_en) begin
    check("a_rdy", a_rdy, (D - qa.size()) >= NC);
    check("a_occ", a_occ, qa.size());
    check("a_vld", a_ovld, ea_vld);
    for (int k = 0; k < 2; k++) begin
      check("a_addr", a_oaddr[k*AW +: AW], ea_addr[k]);
      check("a_data", a_odata[k*DW +: DW], ea_data[k]);
    end
    check("b_rdy", b_rdy, (D - qb.size()) >= NC);
    check("b_occ", b_occ, qb.size());
    check("b_vld", b_ovld, eb_vld);
    check("b_addr", b_oaddr, eb_addr);
    check("b_data", b_odata, eb_data);
    if (b_ovld[0]) b_wr_cnt++;
  end
  task automatic drive_a(input logic [1:0] v, input logic [1:0] dv, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    a_vld = v; a_dv = dv; a_reg = {r1, r0}; a_data = {d1, d0};
    @(negedge clk);
    a_vld = '0;
    @(negedge clk);
  endtask
  int seq, guard;
  bit acc, saw_low;
  initial begin
    a_vld = '0; a_dv = '0; a_reg = '0; a_data = '0;
    b_vld = '0; b_dv = '0; b_reg = '0; b_data = '0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    reset = 1'b0;
    check("rst_rdy", a_rdy, 1);
    check("rst_occ", a_occ, 0);
    check("rst_vld", a_ovld, 0);
    drive_a(2'b11, 2'b11, 5'd3, 5'd4, 32'hDEADBEEF, 32'h12345678);
    check("t1_vld", a_ovld, 2'b11);
    check("t1_p0", {a_oaddr[0 +: AW], a_odata[0 +: DW]}, {5'd3, 32'hDEADBEEF});
    check("t1_p1", {a_oaddr[AW +: AW], a_odata[DW +: DW]}, {5'd4, 32'h12345678});
    check("t1_occ", a_occ, 0);
    drive_a(2'b10, 2'b10, 5'd0, 5'd7, 32'h0, 32'hA5);
    check("t2_vld", a_ovld, 2'b01);
    check("t2_p0", {a_oaddr[0 +: AW], a_odata[0 +: DW]}, {5'd7, 32'hA5});
    drive_a(2'b11, 2'b11, 5'd5, 5'd5, 32'h1, 32'h2);
    check("t3_vld", a_ovld, 2'b10);
    check("t3_p1", {a_oaddr[AW +: AW], a_odata[DW +: DW]}, {5'd5, 32'h2});
    check("t3_p0", {a_oaddr[0 +: AW], a_odata[0 +: DW]}, 0);
    drive_a(2'b11, 2'b01, 5'd0, 5'd9, 32'h11, 32'h22);
    check("t4_vld", a_ovld, 2'b00);
    acc = 1;
    repeat (300) begin
      if (acc) begin
        a_vld = 2'($urandom); a_dv = 2'($urandom);
        a_reg = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
        a_data = {$urandom, $urandom};
      end
      acc = a_rdy;
      @(negedge clk);
    end
    a_vld = '0;
    repeat (3) @(negedge clk);
    seq = 0; acc = 1; saw_low = 0;
    repeat (24) begin
      if (acc) begin
        b_vld = 2'b11; b_dv = 2'b11;
        b_reg = {rg(seq + 1), rg(seq)}; b_data = {32'(seq + 1), 32'(seq)};
        seq += 2;
      end
      acc = b_rdy;
      if (!b_rdy) saw_low = 1;
      @(negedge clk);
    end
    b_vld = '0;
    guard = 0;
    while (b_occ != 0 && guard < 40) begin @(negedge clk); guard++; end
    @(negedge clk);
    check("b_drained", b_occ, 0);
    check("b_saw_full", saw_low, 1);
    check("b_no_loss", b_wr_cnt, b_acc_cnt);
    guard = 0;
    while (b_occ < 6 && guard < 20) begin
      b_vld = 2'b11; b_dv = 2'b11;
      b_reg = {rg(seq + 1), rg(seq)}; b_data = {32'(seq + 1), 32'(seq)};
      seq += 2;
      @(negedge clk);
      guard++;
    end
    check("b_fill_occ", b_occ, 6);
    b_vld = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_vld", b_ovld, 0);
    check("rst2_occ", b_occ, 0);
    check("rst2_rdy", b_rdy, 1);
    repeat (10) @(negedge clk);
    b_vld = 2'b01; b_dv = 2'b01; b_reg = {5'd0, 5'd9}; b_data = {32'h0, 32'hCAFE};
    @(negedge clk);
    b_vld = '0;
    @(negedge clk);
    check("post_rst_wr", {b_ovld, b_oaddr, b_odata}, {1'b1, 5'd9, 32'hCAFE});
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
